logic_axi4_stream_upsizer: RTL and testbench



---
 rtl/logic_axi4_stream_upsizer_if.sv | 26 ++
 rtl/logic_axi4_stream_upsizer.sv | 123 ++++++++++++
 tb/tb_logic_axi4_stream_upsizer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_axi4_stream_upsizer_if.sv
// Narrow rx / wide tx AXI4-Stream signal bundle for logic_axi4_stream_upsizer.
// slave is the upsizer's view; master is the view of whatever drives it.
interface logic_axi4_stream_upsizer_if #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
);
    logic                   rx_tvalid;
    logic [WIDTH-1:0]       rx_tdata;
    logic                   rx_tlast;
    logic                   rx_tready;
    logic                   tx_tvalid;
    logic [WIDTH*RATIO-1:0] tx_tdata;
    logic [RATIO-1:0]       tx_tkeep;
    logic                   tx_tlast;
    logic                   tx_tready;

    modport slave (
        input  rx_tvalid, rx_tdata, rx_tlast, tx_tready,
        output rx_tready, tx_tvalid, tx_tdata, tx_tkeep, tx_tlast
    );

    modport master (
        output rx_tvalid, rx_tdata, rx_tlast, tx_tready,
        input  rx_tready, tx_tvalid, tx_tdata, tx_tkeep, tx_tlast
    );
endinterface

// File: rtl/logic_axi4_stream_upsizer.sv
// Packs RATIO narrow AXI4-Stream beats into one wide beat, lane 0 first; partial words flush on rx_tlast.
// Optional idle-timeout flush of partial words: define LOGIC_AXI4_STREAM_UPSIZER_TIMEOUT_EN.
module logic_axi4_stream_upsizer #(
    parameter int WIDTH   = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic aclk,
    input  logic reset,
    logic_axi4_stream_upsizer_if.slave bus
);
    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int DW = WIDTH * RATIO;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    acc_q, acc_d, accWith;
    logic [RATIO-1:0] keep_q, keep_d, keepWith;
    logic             txValid_q, txValid_d;
    logic [DW-1:0]    txData_q, txData_d;
    logic [RATIO-1:0] txKeep_q, txKeep_d;
    logic             txLast_q, txLast_d;

    logic rxReady, accept, complete, txFree, flush;

    assign txFree   = !txValid_q || bus.tx_tready;
    assign rxReady  = !reset && txFree;
    assign accept   = bus.rx_tvalid && rxReady;
    assign complete = accept && ((cnt_q == CW'(RATIO - 1)) || bus.rx_tlast);

    assign bus.rx_tready = rxReady;
    assign bus.tx_tvalid = txValid_q;
    assign bus.tx_tdata  = txData_q;
    assign bus.tx_tkeep  = txKeep_q;
    assign bus.tx_tlast  = txLast_q;

`ifdef LOGIC_AXI4_STREAM_UPSIZER_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_q, idle_d;

    // Idle counter saturates at TIMEOUT so a flush blocked by a busy tx register fires once it drains.
    always_comb begin
        idle_d = idle_q;
        flush  = (cnt_q != '0) && !accept && (idle_q == IW'(TIMEOUT)) && txFree;
        if (accept || (cnt_q == '0) || flush) begin
            idle_d = '0;
        end else if (idle_q != IW'(TIMEOUT)) begin
            idle_d = idle_q + IW'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign flush = 1'b0;
`endif

    always_comb begin
        accWith                     = acc_q;
        accWith[cnt_q*WIDTH +: WIDTH] = bus.rx_tdata;
        keepWith                    = keep_q;
        keepWith[cnt_q]             = 1'b1;

        cnt_d     = cnt_q;
        acc_d     = acc_q;
        keep_d    = keep_q;
        txValid_d = txValid_q;
        txData_d  = txData_q;
        txKeep_d  = txKeep_q;
        txLast_d  = txLast_q;

        if (txValid_q && bus.tx_tready) begin
            txValid_d = 1'b0;
        end

        // The accumulator is cleared on every hand-off, so unkept lanes reach tx as zero.
        if (complete) begin
            txValid_d = 1'b1;
            txData_d  = accWith;
            txKeep_d  = keepWith;
            txLast_d  = bus.rx_tlast;
            acc_d     = '0;
            keep_d    = '0;
            cnt_d     = '0;
        end else if (accept) begin
            acc_d  = accWith;
            keep_d = keepWith;
            cnt_d  = cnt_q + CW'(1);
        end else if (flush) begin
            txValid_d = 1'b1;
            txData_d  = acc_q;
            txKeep_d  = keep_q;
            txLast_d  = 1'b0;
            acc_d     = '0;
            keep_d    = '0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            keep_q    <= '0;
            txValid_q <= 1'b0;
            txData_q  <= '0;
            txKeep_q  <= '0;
            txLast_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            keep_q    <= keep_d;
            txValid_q <= txValid_d;
            txData_q  <= txData_d;
            txKeep_q  <= txKeep_d;
            txLast_q  <= txLast_d;
        end
    end
endmodule

// File: tb/tb_logic_axi4_stream_upsizer.sv
// Randomised self-checking bench for logic_axi4_stream_upsizer against a beat-list reference model.
// Test 6 adapts to whether LOGIC_AXI4_STREAM_UPSIZER_TIMEOUT_EN is defined.
module tb_logic_axi4_stream_upsizer;
    localparam int WIDTH   = 8;
    localparam int RATIO   = 4;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [WIDTH*RATIO-1:0] data;
        logic [RATIO-1:0]       keep;
        logic                   last;
    } word_t;

    logic aclk;
    logic reset;

    logic_axi4_stream_upsizer_if #(.WIDTH(WIDTH), .RATIO(RATIO)) bus ();

    logic_axi4_stream_upsizer #(.WIDTH(WIDTH), .RATIO(RATIO), .TIMEOUT(TIMEOUT)) dut (
        .aclk  (aclk),
        .reset (reset),
        .bus   (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checkCount = 0;
    int passCount  = 0;
    int txCount    = 0;
    int txLastCount = 0;
    int stallCount = 0;
    bit flushAllowed = 1'b0;
    bit expectValid  = 1'b0;
    logic [WIDTH-1:0] partBeats[$];
    word_t expQ[$];
    word_t lastWord;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic word_t buildWord(input logic [WIDTH-1:0] beats[$], input logic last);
        word_t w;
        w.data = '0;
        w.keep = '0;
        for (int i = 0; i < beats.size(); i++) begin
            w.data = w.data | ((WIDTH*RATIO)'(beats[i]) << (i * WIDTH));
            w.keep = w.keep | (RATIO'(1) << i);
        end
        w.last = last;
        return w;
    endfunction

    // Reference model: collect accepted beats, emit a word after RATIO beats or on tlast.
    always @(negedge aclk) begin
        word_t w;
        if (reset) begin
            partBeats.delete();
            expQ.delete();
            expectValid = 1'b0;
        end else begin
            if (expectValid) begin
                checkOutput("latency tvalid", 64'(bus.tx_tvalid), 64'd1);
                expectValid = 1'b0;
            end
            if (bus.tx_tvalid && bus.tx_tready) begin
                txCount++;
                if (bus.tx_tlast) txLastCount++;
                lastWord.data = bus.tx_tdata;
                lastWord.keep = bus.tx_tkeep;
                lastWord.last = bus.tx_tlast;
                if (expQ.size() == 0 && flushAllowed && partBeats.size() > 0) begin
                    w = buildWord(partBeats, 1'b0);
                    partBeats.delete();
                    checkOutput("flush tdata", 64'(bus.tx_tdata), 64'(w.data));
                    checkOutput("flush tkeep", 64'(bus.tx_tkeep), 64'(w.keep));
                    checkOutput("flush tlast", 64'(bus.tx_tlast), 64'(w.last));
                end else if (expQ.size() == 0) begin
                    checkOutput("unexpected tx beat", 64'd1, 64'd0);
                end else begin
                    w = expQ.pop_front();
                    checkOutput("tx tdata", 64'(bus.tx_tdata), 64'(w.data));
                    checkOutput("tx tkeep", 64'(bus.tx_tkeep), 64'(w.keep));
                    checkOutput("tx tlast", 64'(bus.tx_tlast), 64'(w.last));
                end
            end
            if (bus.rx_tvalid && bus.rx_tready) begin
                partBeats.push_back(bus.rx_tdata);
                if (partBeats.size() == RATIO || bus.rx_tlast) begin
                    expQ.push_back(buildWord(partBeats, bus.rx_tlast));
                    partBeats.delete();
                    expectValid = 1'b1;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic l);
        bit accepted = 1'b0;
        bus.rx_tvalid = 1'b1;
        bus.rx_tdata  = d;
        bus.rx_tlast  = l;
        for (int i = 0; i < 1000; i++) begin
            @(negedge aclk);
            if (bus.rx_tready) begin
                accepted = 1'b1;
                break;
            end
            if (i == 0) stallCount++;
        end
        if (!accepted) checkOutput("rx accept timeout", 64'd0, 64'd1);
        @(posedge aclk);
        #1;
        bus.rx_tvalid = 1'b0;
        bus.rx_tlast  = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    initial begin
        logic [WIDTH*RATIO-1:0] heldData;
        int txBefore;
        int lastBefore;
        int seenValid;
        bit done;

        reset         = 1'b1;
        bus.rx_tvalid = 1'b0;
        bus.rx_tdata  = '0;
        bus.rx_tlast  = 1'b0;
        bus.tx_tready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checkOutput("reset tvalid", 64'(bus.tx_tvalid), 64'd0);
        checkOutput("reset tdata", 64'(bus.tx_tdata), 64'd0);
        checkOutput("reset tkeep", 64'(bus.tx_tkeep), 64'd0);
        checkOutput("reset tlast", 64'(bus.tx_tlast), 64'd0);
        checkOutput("reset rx_tready", 64'(bus.rx_tready), 64'd0);
        @(posedge aclk);
        #1;
        reset = 1'b0;

        $display("[TB] test 1: full word");
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b0);
        idleCycles(3);
        checkOutput("t1 tdata", 64'(lastWord.data), 64'h44332211);
        checkOutput("t1 tkeep", 64'(lastWord.keep), 64'hF);
        checkOutput("t1 tlast", 64'(lastWord.last), 64'd0);

        $display("[TB] test 2: short packet");
        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'hBB, 1'b1);
        idleCycles(3);
        checkOutput("t2 tdata", 64'(lastWord.data), 64'h0000BBAA);
        checkOutput("t2 tkeep", 64'(lastWord.keep), 64'h3);
        checkOutput("t2 tlast", 64'(lastWord.last), 64'd1);

        $display("[TB] test 3: backpressure");
        bus.tx_tready = 1'b0;
        for (int i = 0; i < RATIO; i++) applyStimulus(WIDTH'(8'hC0 + i), 1'b0);
        @(negedge aclk);
        heldData = bus.tx_tdata;
        checkOutput("t3 held data", 64'(heldData), 64'hC3C2C1C0);
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            checkOutput("t3 rx_tready low", 64'(bus.rx_tready), 64'd0);
            checkOutput("t3 tvalid held", 64'(bus.tx_tvalid), 64'd1);
            checkOutput("t3 tdata stable", 64'(bus.tx_tdata), 64'(heldData));
        end
        txBefore = txCount;
        @(posedge aclk);
        #1;
        bus.tx_tready = 1'b1;
        for (int i = 0; i < RATIO; i++) applyStimulus(WIDTH'($urandom), 1'b0);
        idleCycles(3);
        checkOutput("t3 word count", 64'(txCount - txBefore), 64'd2);

        $display("[TB] test 4: streaming");
        txBefore   = txCount;
        lastBefore = txLastCount;
        stallCount = 0;
        for (int i = 0; i < 64; i++) applyStimulus(WIDTH'($urandom), (i == 63));
        idleCycles(3);
        checkOutput("t4 word count", 64'(txCount - txBefore), 64'd16);
        checkOutput("t4 tlast count", 64'(txLastCount - lastBefore), 64'd1);
        checkOutput("t4 rx stalls", 64'(stallCount), 64'd0);

        $display("[TB] test 5: reset mid-word");
        applyStimulus(8'hE1, 1'b0);
        applyStimulus(8'hE2, 1'b0);
        reset = 1'b1;
        @(negedge aclk);
        checkOutput("t5 rx_tready in reset", 64'(bus.rx_tready), 64'd0);
        @(posedge aclk);
        #1;
        checkOutput("t5 tvalid in reset", 64'(bus.tx_tvalid), 64'd0);
        reset = 1'b0;
        for (int i = 1; i <= RATIO; i++) applyStimulus(WIDTH'(i), 1'b0);
        idleCycles(3);
        checkOutput("t5 tdata", 64'(lastWord.data), 64'h04030201);
        checkOutput("t5 tkeep", 64'(lastWord.keep), 64'hF);

        $display("[TB] test 6: idle partial word");
        txBefore  = txCount;
        seenValid = 0;
`ifdef LOGIC_AXI4_STREAM_UPSIZER_TIMEOUT_EN
        flushAllowed = 1'b1;
        applyStimulus(8'h5A, 1'b0);
        for (int i = 0; i < TIMEOUT + 10; i++) begin
            @(negedge aclk);
            if (bus.tx_tvalid && seenValid == 0) seenValid = i + 1;
        end
        checkOutput("t6 flush seen", 64'(seenValid != 0), 64'd1);
        checkOutput("t6 flush tdata", 64'(lastWord.data), 64'h0000005A);
        checkOutput("t6 flush tkeep", 64'(lastWord.keep), 64'h1);
        checkOutput("t6 flush tlast", 64'(lastWord.last), 64'd0);
        flushAllowed = 1'b0;
        idleCycles(1);
`else
        applyStimulus(8'h5A, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (bus.tx_tvalid) seenValid++;
        end
        checkOutput("t6 no tx while idle", 64'(seenValid), 64'd0);
        idleCycles(1);
        applyStimulus(8'h5B, 1'b1);
        idleCycles(3);
        checkOutput("t6 tdata", 64'(lastWord.data), 64'h00005B5A);
        checkOutput("t6 tkeep", 64'(lastWord.keep), 64'h3);
        checkOutput("t6 tlast", 64'(lastWord.last), 64'd1);
`endif

        $display("[TB] random traffic with random tx_tready");
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    applyStimulus(WIDTH'($urandom), ($urandom_range(0, 4) == 0));
                    if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 2));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge aclk);
                    #1;
                    bus.tx_tready = ($urandom_range(0, 9) < 7);
                end
            end
        join
        bus.tx_tready = 1'b1;
        applyStimulus(WIDTH'($urandom), 1'b1);
        idleCycles(5);
        checkOutput("final queue empty", 64'(expQ.size()), 64'd0);
        checkOutput("final tvalid idle", 64'(bus.tx_tvalid), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
